// File: rtl/moore_serial_tx.sv
// Moore serial frame transmitter: 0,1 preamble, two guard cycles, LSB-first payload, stop bit.
// Outputs depend only on registered state, so nothing from the inputs reaches the line combinationally.
module moore_serial_tx #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data,
    output logic             out,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        SYNC   = 3'd2,
        GUARD0 = 3'd3,
        GUARD1 = 3'd4,
        DATA   = 3'd5,
        STOP   = 3'd6
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] shift;
    logic [WIDTH-1:0] shift_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            shift <= '0;
            count <= '0;
        end else begin
            state <= state_next;
            shift <= shift_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        shift_next = shift;
        count_next = count;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = START;
                    shift_next = data;
                    count_next = '0;
                end
            end
            START:  state_next = SYNC;
            SYNC:   state_next = GUARD0;
            GUARD0: state_next = GUARD1;
            GUARD1: state_next = DATA;
            DATA: begin
                shift_next = {1'b0, shift[WIDTH-1:1]};
                // Counter saturates at the last bit so it never wraps inside a frame.
                if (count == LAST) begin
                    state_next = STOP;
                end else begin
                    count_next = count + CNT_W'(1);
                end
            end
            STOP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        out  = 1'b1;
        busy = (state != IDLE);
        done = (state == STOP);
        case (state)
            START:   out = 1'b0;
            DATA:    out = shift[0];
            default: out = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_moore_serial_tx.sv
// Bench for moore_serial_tx: frame-position model checked every cycle plus literal frame patterns.
module tb_moore_serial_tx;

    localparam int W    = 8;
    localparam int FLEN = W + 5;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] data  = '0;
    logic         out;
    logic         busy;
    logic         done;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    // Model: position within the frame (0 = idle, 1 = START ... FLEN = STOP) and the captured word.
    int           mpos  = 0;
    logic [W-1:0] mdata = '0;

    moore_serial_tx #(.WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
        .start(start),
        .data (data),
        .out  (out),
        .busy (busy),
        .done (done)
    );

    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mpos <= 0;
        end else if (mpos == 0) begin
            if (start === 1'b1) begin
                mpos  <= 1;
                mdata <= data;
            end
        end else if (mpos == FLEN) begin
            mpos <= 0;
        end else begin
            mpos <= mpos + 1;
        end
    end

    function automatic logic exp_out(input int p, input logic [W-1:0] d);
        if (p == 1) return 1'b0;
        if (p >= 5 && p < 5 + W) return d[p-5];
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (check_en) begin
            check("model_out",  {31'b0, out},  {31'b0, exp_out(mpos, mdata)});
            check("model_busy", {31'b0, busy}, {31'b0, (mpos != 0)});
            check("model_done", {31'b0, done}, {31'b0, (mpos == FLEN)});
        end
    end

    // Launch one frame from idle and record out/busy/done for 14 cycles; optionally pulse start mid-frame.
    task automatic run_frame(input logic [W-1:0] d, input int inj_at,
                             output logic [0:13] so, output logic [0:13] sb, output logic [0:13] sd);
        start = 1'b1;
        data  = d;
        @(posedge clock);
        #2 start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            so[i] = out;
            sb[i] = busy;
            sd[i] = done;
            if (i == inj_at) begin
                start = 1'b1;
                data  = 8'h3C;
            end else if (i == inj_at + 1) begin
                start = 1'b0;
            end
        end
        @(posedge clock);
        #2;
    endtask

    logic [0:13] so, sb, sd;
    logic [0:27] ho, hb;

    initial begin
        #1 reset = 1'b1;
        start = 1'b1;
        data  = 8'hFF;
        #1 check_en = 1'b1;
        check("reset_out",  {31'b0, out},  32'd1);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        repeat (3) @(negedge clock);
        start = 1'b0;
        reset = 1'b0;
        @(posedge clock);
        #2;

        // Asynchronous reset between edges while idle.
        reset = 1'b1;
        #1 check("async_idle_out", {31'b0, out}, 32'd1);
        check("async_idle_busy", {31'b0, busy}, 32'd0);
        #1 reset = 1'b0;
        @(posedge clock);
        #2;

        run_frame(8'hA5, -5, so, sb, sd);
        check("a5_out",  {18'b0, so}, {18'b0, 14'b0111_1010_0101_11});
        check("a5_busy", {18'b0, sb}, {18'b0, 14'b1111_1111_1111_10});
        check("a5_done", {18'b0, sd}, {18'b0, 14'b0000_0000_0000_10});

        run_frame(8'h00, -5, so, sb, sd);
        check("00_out",  {18'b0, so}, {18'b0, 14'b0111_0000_0000_11});
        check("00_busy", {18'b0, sb}, {18'b0, 14'b1111_1111_1111_10});

        run_frame(8'hFF, -5, so, sb, sd);
        check("ff_out",  {18'b0, so}, {18'b0, 14'b0111_1111_1111_11});
        check("ff_done", {18'b0, sd}, {18'b0, 14'b0000_0000_0000_10});

        // Request with 3C raised during DATA of an A5 frame must be dropped.
        run_frame(8'hA5, 6, so, sb, sd);
        check("mid_out",  {18'b0, so}, {18'b0, 14'b0111_1010_0101_11});
        check("mid_busy", {18'b0, sb}, {18'b0, 14'b1111_1111_1111_10});
        repeat (3) begin
            @(negedge clock);
            check("mid_no_frame", {31'b0, busy}, 32'd0);
        end
        @(posedge clock);
        #2;

        // Start held high: 14-cycle period with one idle cycle between frames.
        start = 1'b1;
        data  = 8'h81;
        @(posedge clock);
        for (int i = 0; i < 28; i++) begin
            @(negedge clock);
            ho[i] = out;
            hb[i] = busy;
            if (i == 27) start = 1'b0;
        end
        check("held_out",  {4'b0, ho}, {4'b0, 28'b0111_1000_0001_11_0111_1000_0001_11});
        check("held_busy", {4'b0, hb}, {4'b0, 28'b1111_1111_1111_10_1111_1111_1111_10});
        @(posedge clock);
        #2;

        // Reset in the third DATA cycle of an A5 frame, then a fresh 0F frame.
        start = 1'b1;
        data  = 8'hA5;
        @(posedge clock);
        #2 start = 1'b0;
        repeat (7) @(negedge clock);
        check("pre_reset_busy", {31'b0, busy}, 32'd1);
        #1 reset = 1'b1;
        start = 1'b1;
        #1 check("midrst_out", {31'b0, out}, 32'd1);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        repeat (2) @(negedge clock);
        check("held_rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        @(posedge clock);
        #2;
        run_frame(8'h0F, -5, so, sb, sd);
        check("0f_out",  {18'b0, so}, {18'b0, 14'b0111_1111_0000_11});
        check("0f_busy", {18'b0, sb}, {18'b0, 14'b1111_1111_1111_10});
        check("0f_done", {18'b0, sd}, {18'b0, 14'b0000_0000_0000_10});

        repeat (3) @(posedge clock);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/moore_serial_tx.md
# moore_serial_tx

Moore-style serial frame transmitter: captures a parallel word on a start request and shifts it out on a single-bit line. Each frame begins with a `0`,`1` preamble followed by two fixed guard cycles. This matches our Moore sequence-detector receiver, which advances on `0`, then `1`, then passes through two input-independent states before returning to idle. The block sits on the transmit side of that link and drives the receiver's `in` directly.

## Interface
- `WIDTH`, default 8: payload bits per frame; legal range is WIDTH >= 2.
- `clock` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: asynchronous, active-high; forces the block to IDLE immediately.
- `start` input 1: frame request; sampled only in IDLE.
- `data` input WIDTH: payload; captured on the edge that accepts `start`.
- `out` output 1: serial line; idle level is `1`.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: high only during the STOP cycle.

## Operation
- States: IDLE, START, SYNC, GUARD0, GUARD1, DATA, STOP. Encode them in a 3-bit state register.
- Outputs are a function of the state register, the shift register and the bit counter only. No input reaches `out`, `busy` or `done` combinationally.
- `out` per state:
  - IDLE = 1, START = 0, SYNC = 1.
  - GUARD0 = 1, GUARD1 = 1.
  - DATA = shift register bit 0.
  - STOP = 1.
- Transitions:
  - IDLE → START when `start` = 1. On the same edge, `data` loads into the shift register and the bit counter clears to 0.
  - IDLE → IDLE otherwise.
  - START → SYNC → GUARD0 → GUARD1 → DATA, unconditionally, one cycle each.
  - DATA: each edge shifts the register right by one (zero fill) and increments the counter. When the counter equals WIDTH-1, the next state is STOP; otherwise the block stays in DATA.
  - STOP → IDLE unconditionally.
- Payload is sent LSB first.
- Bit counter width is $clog2(WIDTH). It never exceeds WIDTH-1 and does not wrap inside a frame.
- `start` and `data` are ignored in every non-IDLE state. A request raised mid-frame is dropped, not queued.
- `start` held high continuously: after STOP the block spends exactly one cycle in IDLE, then accepts the next frame. Consecutive frames are therefore separated by one idle `1` cycle.
- Reset, asynchronous, at any point including mid-frame:
  - state = IDLE, shift register = 0, counter = 0.
  - `out` = 1, `busy` = 0, `done` = 0.
  - After reset deasserts, the first rising edge with `start` = 1 starts a fresh frame. The aborted frame is not resumed.

## Timing
- Acceptance edge = the edge where IDLE samples `start` = 1. Call it edge 0.
- After edge 0: `out` = 0 (START) and `busy` = 1.
- Frame length = 4 + WIDTH + 1 cycles, START through STOP inclusive. For WIDTH = 8 this is 13 cycles.
- Payload bit k is on `out` in cycle 5+k after edge 0, for k = 0..WIDTH-1.
- STOP occupies cycle 5+WIDTH. `done` = 1 and `busy` = 1 in that cycle only.
- The following cycle is IDLE: `busy` = 0, `done` = 0.
- Minimum start-to-start spacing is 6 + WIDTH cycles.

## Test plan
- **Reset values:** assert `reset` asynchronously between clock edges → `out` = 1, `busy` = 0, `done` = 0 immediately; no change while `reset` is held, regardless of `start`.
- **Single frame:** WIDTH = 8, `data` = 8'hA5, one-cycle `start` → `out` per cycle from edge 0 = 0,1,1,1, 1,0,1,0,0,1,0,1, 1, then idle 1. `busy` is high for 13 cycles; `done` is high only in the 13th.
- **Edge payloads:** `data` = 8'h00 and 8'hFF → 8 data cycles of 0 and of 1 respectively. Preamble and guard cycles are unchanged; frame length is 13 in both cases.
- **Mid-frame request:** pulse `start` with `data` = 8'h3C during DATA of an 8'hA5 frame → the A5 frame completes unchanged; no second frame follows and `busy` falls after STOP.
- **Held start:** hold `start` = 1 with `data` = 8'h81 → frames repeat with exactly one IDLE cycle between STOP and the next START (14-cycle period); each frame's payload is 1,0,0,0,0,0,0,1.
- **Reset mid-frame:** assert `reset` in the 3rd DATA cycle → outputs return to idle values at once. After release, a `start` with 8'h0F yields a complete, correct 13-cycle frame.
